// File: rtl/switch_led_io.sv
// rtl/switch_led_io.sv - memory-mapped 24-bit LED bank and debounced 24-bit switch bank
//
// Purpose: drives a registered 24-bit LED bank from CPU stores and returns a
// synchronised (and optionally debounced) image of 24 board switches to CPU loads.
//
// Ports:
//   clock        in   1   system clock, rising-edge
//   reset        in   1   asynchronous active-high reset
//   led_ctrl     in   1   LED chip-select (store)
//   switch_ctrl  in   1   switch chip-select (load)
//   addr_in      in  32   byte address
//   write_data   in  32   store data
//   switch_in    in  24   raw asynchronous switch levels
//   led_out      out 24   registered LED drive
//   io_rdata     out 16   switch read data
//
// Configuration macro: SWITCH_DEBOUNCE_EN
//   defined   - switches must be stable for DEBOUNCE_CYCLES edges before acceptance
//   undefined - stable image follows the synchroniser output directly

module switch_led_io #(
  parameter logic [31:0] LED_ADDR        = 32'hFFFF_FC60,
  parameter logic [31:0] SW_ADDR         = 32'hFFFF_FC70,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        led_ctrl,
  input  logic        switch_ctrl,
  input  logic [31:0] addr_in,
  input  logic [31:0] write_data,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out,
  output logic [15:0] io_rdata
);

  localparam logic [31:0] LED_HI_ADDR = LED_ADDR + 32'd2;
  localparam logic [31:0] SW_HI_ADDR  = SW_ADDR + 32'd2;

  // Only the low half-word of the store bus ever reaches the LEDs.
  logic unused_wdata;
  assign unused_wdata = ^write_data[31:16];

  // ---------------------------------------------------------------------------
  // LED bank
  // ---------------------------------------------------------------------------
  logic [23:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (led_ctrl) begin
      if (addr_in == LED_ADDR) begin
        led_d[15:0] = write_data[15:0];
      end else if (addr_in == LED_HI_ADDR) begin
        led_d[23:16] = write_data[7:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_out = led_q;

  // ---------------------------------------------------------------------------
  // Switch synchroniser
  // ---------------------------------------------------------------------------
  logic [23:0] s1_q, s2_q;
  logic [23:0] stable_q, stable_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= switch_in;
      s2_q <= s1_q;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debouncer: one shared counter for the whole vector, so any bit changing
  // restarts acceptance for every switch.
  // ---------------------------------------------------------------------------
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [23:0]   cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q) begin
      // Accept on the last count value; the counter never runs past it.
      if (cnt_q == CNT_LAST) begin
        stable_d = cand_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
`else
  always_comb begin
    stable_d = s2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Switch read path (combinational from the registered stable image)
  // ---------------------------------------------------------------------------
  always_comb begin
    io_rdata = 16'h0000;
    if (switch_ctrl) begin
      if (addr_in == SW_ADDR) begin
        io_rdata = stable_q[15:0];
      end else if (addr_in == SW_HI_ADDR) begin
        io_rdata = {8'h00, stable_q[23:16]};
      end
    end
  end

endmodule

// File: tb/tb_switch_led_io.sv
// tb/tb_switch_led_io.sv - randomized model-checked bench for switch_led_io

module tb_switch_led_io;

  localparam logic [31:0] LED_A = 32'hFFFF_FC60;
  localparam logic [31:0] SW_A  = 32'hFFFF_FC70;
  localparam int D = 4;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int W   = D + 1;
  localparam int LAT = D + 3;
`else
  localparam int W   = 1;
  localparam int LAT = 3;
`endif

  logic        clock;
  logic        reset;
  logic        led_ctrl;
  logic        switch_ctrl;
  logic [31:0] addr_in;
  logic [31:0] write_data;
  logic [23:0] switch_in;
  logic [23:0] led_out;
  logic [15:0] io_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  switch_led_io #(
    .LED_ADDR       (LED_A),
    .SW_ADDR        (SW_A),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .led_ctrl   (led_ctrl),
    .switch_ctrl(switch_ctrl),
    .addr_in    (addr_in),
    .write_data (write_data),
    .switch_in  (switch_in),
    .led_out    (led_out),
    .io_rdata   (io_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Reference model: the stable image takes value v once the synchronised
  // switches have shown v on W consecutive edges.
  logic [23:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_led = '0;
  logic [23:0] win[$];
  bit          same;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_led = '0;
      win.delete();
    end else begin
      win.push_back(m_s2);
      if (win.size() > W) void'(win.pop_front());
      if (win.size() == W) begin
        same = 1'b1;
        foreach (win[i]) if (win[i] != win[0]) same = 1'b0;
        if (same) m_stable = win[0];
      end
      m_s2 = m_s1;
      m_s1 = switch_in;
      if (led_ctrl) begin
        if (addr_in == LED_A) m_led[15:0] = write_data[15:0];
        else if (addr_in == LED_A + 32'd2) m_led[23:16] = write_data[7:0];
      end
    end
  end

  function automatic logic [15:0] exp_io();
    if (reset || !switch_ctrl) return 16'h0;
    if (addr_in == SW_A) return m_stable[15:0];
    if (addr_in == SW_A + 32'd2) return {8'h00, m_stable[23:16]};
    return 16'h0;
  endfunction

  initial forever begin
    @(negedge clock);
    check("led_out_model", {8'h0, led_out}, {8'h0, m_led});
    check("io_rdata_model", {16'h0, io_rdata}, {16'h0, exp_io()});
  end

  logic [31:0] addr_tab [6];
  logic [23:0] base;
  int          hold;

  initial begin
    reset = 1'b1; led_ctrl = 0; switch_ctrl = 0; addr_in = 0; write_data = 0; switch_in = 0;
    addr_tab[0] = LED_A; addr_tab[1] = LED_A + 32'd2; addr_tab[2] = SW_A;
    addr_tab[3] = SW_A + 32'd2; addr_tab[4] = 32'hFFFF_FC64; addr_tab[5] = 32'h0000_1000;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // LED half-word / byte writes
    led_ctrl = 1; addr_in = LED_A; write_data = 32'h1234_ABCD;
    cyc(1); check("led_lo_write", {8'h0, led_out}, 32'h0000_ABCD);
    addr_in = LED_A + 32'd2; write_data = 32'h0000_0055;
    cyc(1); check("led_hi_write", {8'h0, led_out}, 32'h0055_ABCD);
    addr_in = 32'hFFFF_FC64; write_data = 32'hFFFF_FFFF;
    cyc(1); check("led_bad_addr", {8'h0, led_out}, 32'h0055_ABCD);
    led_ctrl = 0;

    // Switch latency
    switch_in = 24'hA5_1234; switch_ctrl = 1; addr_in = SW_A;
    for (int k = 1; k <= LAT; k++) begin
      cyc(1);
      check("sw_latency", {16'h0, io_rdata}, (k < LAT) ? 32'h0 : 32'h1234);
    end
    cyc(3); check("sw_hold", {16'h0, io_rdata}, 32'h1234);
    addr_in = SW_A + 32'd2; #1 check("sw_hi_read", {16'h0, io_rdata}, 32'h00A5);
    addr_in = LED_A; #1 check("sw_decode_neg", {16'h0, io_rdata}, 32'h0);

    // Simultaneous chip-selects
    led_ctrl = 1; addr_in = SW_A; write_data = 32'h0000_7777;
    #1 check("simul_read", {16'h0, io_rdata}, 32'h1234);
    cyc(1); check("simul_no_led", {8'h0, led_out}, 32'h0055_ABCD);
    addr_in = LED_A;
    #1 check("simul_led_addr_read", {16'h0, io_rdata}, 32'h0);
    cyc(1); check("simul_led_commit", {8'h0, led_out}, 32'h0055_7777);
    led_ctrl = 0; addr_in = SW_A;
    cyc(1);

`ifdef SWITCH_DEBOUNCE_EN
    // Short bounce on bit 0 never reaches the stable image
    switch_in[0] = 1'b1; cyc(3); switch_in[0] = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      cyc(1); check("bounce_reject", {31'h0, io_rdata[0]}, 32'h0);
    end
`else
    // One-cycle glitch on bit 1 shows for exactly one cycle
    switch_in[1] = 1'b1; cyc(1); switch_in[1] = 1'b0;
    cyc(1); check("glitch_e2", {31'h0, io_rdata[1]}, 32'h0);
    cyc(1); check("glitch_e3", {31'h0, io_rdata[1]}, 32'h1);
    cyc(1); check("glitch_e4", {31'h0, io_rdata[1]}, 32'h0);
    cyc(4);
`endif
    // Held change on bit 0 accepted exactly LAT edges after the rise
    switch_in[0] = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      cyc(1); check("bit0_accept", {31'h0, io_rdata[0]}, (k >= LAT) ? 32'h1 : 32'h0);
    end

    // Reset in the middle of a count
    switch_in = 24'hFF_FFFF;
    cyc(2);
    reset = 1'b1;
    #1 check("reset_led", {8'h0, led_out}, 32'h0);
    check("reset_io", {16'h0, io_rdata}, 32'h0);
    cyc(2);
    reset = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      cyc(1); check("post_reset_latency", {16'h0, io_rdata}, (k < LAT) ? 32'h0 : 32'hFFFF);
    end

    // Randomized traffic against the model
    base = '0; hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        base = 24'($urandom);
        if ($urandom_range(0, 2) == 0) base = base & 24'h00_000F;
        hold = $urandom_range(1, 2 * W + 4);
      end
      hold--;
      switch_in   = ($urandom_range(0, 7) == 0) ? (base ^ (24'h1 << $urandom_range(0, 23))) : base;
      led_ctrl    = 1'($urandom_range(0, 1));
      switch_ctrl = 1'($urandom_range(0, 1));
      addr_in     = addr_tab[$urandom_range(0, 5)];
      write_data  = $urandom;
      reset       = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_led_io.md
# switch_led_io

Memory-mapped LED/switch peripheral that sits directly downstream of the memory/IO steering stage. It consumes that stage's LED and switch chip-selects, address and write data. It returns 16-bit switch read data to the same stage. It drives a 24-bit LED bank from CPU stores and presents a synchronised, debounced image of 24 board switches to CPU loads.

## Interface
Parameters:
- `LED_ADDR`, default 32'hFFFF_FC60: base address of the LED bank.
- `SW_ADDR`, default 32'hFFFF_FC70: base address of the switch bank.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of stable cycles required before a switch change is accepted; must be ≥1.

Ports:
- `clock`, in, 1: single system clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `led_ctrl`, in, 1: LED chip-select (store to IO space).
- `switch_ctrl`, in, 1: switch chip-select (load from IO space).
- `addr_in`, in, 32: byte address from the ALU result path.
- `write_data`, in, 32: store data.
- `switch_in`, in, 24: raw, asynchronous board switch levels.
- `led_out`, out, 24: LED drive, registered.
- `io_rdata`, out, 16: switch read data back to the memory/IO steering stage.

## Operation
Address decode (exact 32-bit compare):
- LED_ADDR: low LED half-word.
- LED_ADDR+2: high LED byte.
- SW_ADDR: low switch half-word.
- SW_ADDR+2: high switch byte.

LED writes:
- `led_ctrl`=1 and `addr_in`==LED_ADDR: `led_out[15:0]` ← `write_data[15:0]`.
- `led_ctrl`=1 and `addr_in`==LED_ADDR+2: `led_out[23:16]` ← `write_data[7:0]`.
- `led_ctrl`=1 with any other address: ignored; `led_out` holds.

Switch reads (combinational from the registered `stable` vector):
- `switch_ctrl`=1 and `addr_in`==SW_ADDR: `io_rdata` = `stable[15:0]`.
- `switch_ctrl`=1 and `addr_in`==SW_ADDR+2: `io_rdata` = {8'h00, `stable[23:16]`}.
- Otherwise: `io_rdata` = 16'h0000.

Switch path:
- Two-flop synchroniser `s1` → `s2` on all 24 bits.
- Debouncer registers: `cand` (24-bit), counter `cnt`, `stable` (24-bit). Counter width is $clog2(DEBOUNCE_CYCLES+1).
- If `s2` != `cand`: `cand` ← `s2`, `cnt` ← 0.
- Else if `cand` != `stable`:
  - if `cnt` == DEBOUNCE_CYCLES−1: `stable` ← `cand`, `cnt` ← 0;
  - otherwise `cnt` ← `cnt`+1.
- Else: `cnt` ← 0.
- Any bit change in `s2` restarts the whole count. Bounce on one switch delays acceptance of all switches.
- `cnt` never exceeds DEBOUNCE_CYCLES−1; there is no wrap.

Other rules:
- Simultaneous `led_ctrl` and `switch_ctrl` are independent: the write commits and the read returns the current `stable` value.
- Reset (`reset`=1, asynchronous, at any time, including mid-count) clears `led_out`, `s1`, `s2`, `cand`, `stable` and `cnt` to 0.
- `io_rdata` is 0 while in reset.

## Timing
- LED write: `led_out` updates at the rising edge where `led_ctrl` and the address are valid. It is visible one edge later than the request cycle; there are no wait states.
- Switch read: zero-cycle combinational path from `stable`, so the value is valid in the same cycle as `switch_ctrl`.
- Switch latency with debounce: a raw change held constant before edge 1 reaches `stable` at edge DEBOUNCE_CYCLES+3:
  - edge 1: `s1` updates;
  - edge 2: `s2` updates;
  - edge 3: `cand` updates;
  - DEBOUNCE_CYCLES further edges complete the count.
- A glitch shorter than DEBOUNCE_CYCLES+1 cycles after reaching `cand` never reaches `stable`.
- Reset release: first rising edge after deassertion samples `switch_in` into `s1`.

## Configuration
- Macro: `SWITCH_DEBOUNCE_EN`.
- Defined: debouncer as described in Operation.
- Undefined: `cand` and `cnt` are not built; `stable` ← `s2` every edge; switch latency is 3 edges; `DEBOUNCE_CYCLES` is ignored.

## Test plan
- **Reset:** assert `reset` mid-count with `switch_in`=24'hFFFFFF → `led_out`=0, `io_rdata`=0 immediately; after release, a read at SW_ADDR returns 0 until latency elapses.
- **LED byte/half-word writes:**
  - `led_ctrl`, addr LED_ADDR, data 32'h1234_ABCD → `led_out`=24'h00ABCD.
  - Then addr LED_ADDR+2, data 32'h0000_0055 → `led_out`=24'h55ABCD.
  - Then addr 32'hFFFF_FC64 → unchanged.
- **Debounce latency** (DEBOUNCE_CYCLES=4): step `switch_in` 0 → 24'hA5_1234 → SW_ADDR reads 16'h1234 from edge 7 onward, 0 before; SW_ADDR+2 reads 16'h00A5.
- **Bounce rejection** (DEBOUNCE_CYCLES=4): pulse bit 0 high for 3 cycles → `stable` never changes; then hold high for 10 cycles → bit 0 accepted exactly 7 edges after the final rise.
- **Decode negatives:** `switch_ctrl` with addr 32'hFFFF_FC60 → `io_rdata`=0; simultaneous `led_ctrl`+`switch_ctrl` → LED write commits and read returns current `stable`.
- **Macro off:** recompile without `SWITCH_DEBOUNCE_EN` and step the switches → new value is visible at edge 3; a 1-cycle glitch is visible for one cycle.
